// File: rtl/grid_pkg.sv
// Shared constants and FSM encoding for the grid paint arbiter.
package grid_pkg;

  localparam int unsigned GRID_ADDR_W = 12;
  localparam int unsigned COLOR_W     = 4;
  localparam int unsigned GRID_CELLS  = 1 << GRID_ADDR_W;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } grid_state_e;

endpackage

// File: rtl/grid_clear_sweeper.sv
// Address sweep counter for the grid clear; one bit wider than the address so it never
// wraps back into cell 0 after the last cell has been issued.
module grid_clear_sweeper #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W:0] LastCnt = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] OneCnt  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + OneCnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = cnt_q[ADDR_W-1:0];
  assign last = (cnt_q == LastCnt);

endmodule

// File: rtl/grid_paint_arbiter.sv
// Two-player paint arbiter for the grid RAM write port, with a full-grid clear sweep.
// Grants are combinational; the RAM write port is registered (one cycle latency).
module grid_paint_arbiter #(
  parameter int unsigned        ADDR_W     = grid_pkg::GRID_ADDR_W,
  parameter int unsigned        COLOR_W    = grid_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
  parameter bit                 AUTO_CLEAR = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               p1_req,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [COLOR_W-1:0] p1_color,
  output logic               p1_gnt,
  input  logic               p2_req,
  input  logic [ADDR_W-1:0]  p2_addr,
  input  logic [COLOR_W-1:0] p2_color,
  output logic               p2_gnt,
  input  logic               clear_start,
  output logic               busy,
  output logic               clear_done,
  output logic               wren_gridData,
  output logic [ADDR_W-1:0]  wraddress_gridData,
  output logic [COLOR_W-1:0] data_gridData
);

  import grid_pkg::*;

  grid_state_e        state_q, state_d;
  logic               last_p2_q, last_p2_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sweep_clr;
  logic               sweep_step;
  logic [ADDR_W-1:0]  sweep_addr;
  logic               sweep_last;

  grid_clear_sweeper #(
    .ADDR_W(ADDR_W)
  ) u_sweeper (
    .clock  (clock),
    .resetn (resetn),
    .clr    (sweep_clr),
    .step   (sweep_step),
    .addr   (sweep_addr),
    .last   (sweep_last)
  );

  // On a tie the player that did not win the last transfer goes first.
  always_comb begin
    p1_gnt = 1'b0;
    p2_gnt = 1'b0;
    if (state_q == StArb && !clear_start) begin
      if (p1_req && (!p2_req || last_p2_q)) begin
        p1_gnt = 1'b1;
      end else if (p2_req) begin
        p2_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_clr  = 1'b0;
    sweep_step = 1'b0;
    unique case (state_q)
      StArb: begin
        if (clear_start) begin
          state_d   = StClear;
          sweep_clr = 1'b1;
        end
      end
      StClear: begin
        sweep_step = 1'b1;
        if (sweep_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    wren_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = 1'b0;
    done_d    = (state_q == StDone);
    last_p2_d = last_p2_q;
    if (state_q == StClear) begin
      wren_d = 1'b1;
      addr_d = sweep_addr;
      data_d = BG_COLOR;
      busy_d = 1'b1;
    end else if (p1_gnt && p1_req) begin
      wren_d    = 1'b1;
      addr_d    = p1_addr;
      data_d    = p1_color;
      last_p2_d = 1'b0;
    end else if (p2_gnt && p2_req) begin
      wren_d    = 1'b1;
      addr_d    = p2_addr;
      data_d    = p2_color;
      last_p2_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= AUTO_CLEAR ? StClear : StArb;
      last_p2_q <= 1'b1;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_p2_q <= last_p2_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wren_gridData      = wren_q;
  assign wraddress_gridData = addr_q;
  assign data_gridData      = data_q;
  assign busy               = busy_q;
  assign clear_done         = done_q;

endmodule

// File: tb/tb_grid_paint_arbiter.sv
// Directed bench for grid_paint_arbiter: reset sweep, single grant, tie alternation,
// clear priority over requests, and reset abort mid-sweep.
module tb_grid_paint_arbiter;

  logic        clock;
  logic        resetn;
  logic        p1_req;
  logic [11:0] p1_addr;
  logic [3:0]  p1_color;
  logic        p1_gnt;
  logic        p2_req;
  logic [11:0] p2_addr;
  logic [3:0]  p2_color;
  logic        p2_gnt;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic        wren_gridData;
  logic [11:0] wraddress_gridData;
  logic [3:0]  data_gridData;

  int tests;
  int fails;

  grid_paint_arbiter dut (
    .clock              (clock),
    .resetn             (resetn),
    .p1_req             (p1_req),
    .p1_addr            (p1_addr),
    .p1_color           (p1_color),
    .p1_gnt             (p1_gnt),
    .p2_req             (p2_req),
    .p2_addr            (p2_addr),
    .p2_color           (p2_color),
    .p2_gnt             (p2_gnt),
    .clear_start        (clear_start),
    .busy               (busy),
    .clear_done         (clear_done),
    .wren_gridData      (wren_gridData),
    .wraddress_gridData (wraddress_gridData),
    .data_gridData      (data_gridData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    resetn = 1'b0;
    repeat (2) tick();
    tests++;
    if ({wren_gridData, busy, clear_done, wraddress_gridData, data_gridData} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got wren=%b busy=%b done=%b addr=%0d data=%0d, want all 0",
               wren_gridData, busy, clear_done, wraddress_gridData, data_gridData);
    end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (wren_gridData !== 1'b1 || busy !== 1'b1 || clear_done !== 1'b0 ||
          wraddress_gridData !== 12'(i) || data_gridData !== 4'd0) begin
        if (bad == 0)
          $display("FAIL auto_sweep_write: cycle %0d got wren=%b busy=%b addr=%0d data=%0d, want 1 1 %0d 0",
                   i, wren_gridData, busy, wraddress_gridData, data_gridData, i);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    tick();
    tests++;
    if (clear_done !== 1'b1 || wren_gridData !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL auto_sweep_done: got done=%b wren=%b busy=%b, want 1 0 0",
               clear_done, wren_gridData, busy);
    end
    tick();
    tests++;
    if (clear_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", clear_done, busy);
    end
  endtask

  task automatic test_tie;
    logic        exp_p1;
    logic [3:0]  exp_data;
    logic [11:0] exp_addr;
    p1_req = 1'b1; p1_addr = 12'h010; p1_color = 4'h1;
    p2_req = 1'b1; p2_addr = 12'h020; p2_color = 4'h2;
    for (int k = 0; k < 4; k++) begin
      exp_p1   = (k % 2 == 0);
      exp_data = exp_p1 ? 4'h1 : 4'h2;
      exp_addr = exp_p1 ? 12'h010 : 12'h020;
      #1;
      tests++;
      if (p1_gnt !== exp_p1 || p2_gnt !== !exp_p1) begin
        fails++;
        $display("FAIL tie_grant: round %0d got p1_gnt=%b p2_gnt=%b, want %b %b",
                 k, p1_gnt, p2_gnt, exp_p1, !exp_p1);
      end
      tick();
      tests++;
      if (wren_gridData !== 1'b1 || data_gridData !== exp_data ||
          wraddress_gridData !== exp_addr) begin
        fails++;
        $display("FAIL tie_write: round %0d got wren=%b addr=%h data=%h, want 1 %h %h",
                 k, wren_gridData, wraddress_gridData, data_gridData, exp_addr, exp_data);
      end
    end
    p1_req = 1'b0;
    p2_req = 1'b0;
  endtask

  task automatic test_single_p1;
    p1_req = 1'b1; p1_addr = 12'h123; p1_color = 4'h5;
    #1;
    tests++;
    if (p1_gnt !== 1'b1 || p2_gnt !== 1'b0) begin
      fails++;
      $display("FAIL single_grant: got p1_gnt=%b p2_gnt=%b, want 1 0", p1_gnt, p2_gnt);
    end
    tick();
    p1_req = 1'b0;
    tests++;
    if (wren_gridData !== 1'b1 || wraddress_gridData !== 12'h123 || data_gridData !== 4'h5) begin
      fails++;
      $display("FAIL single_write: got wren=%b addr=%h data=%h, want 1 123 5",
               wren_gridData, wraddress_gridData, data_gridData);
    end
    tick();
    tests++;
    if (wren_gridData !== 1'b0 || wraddress_gridData !== 12'h123 || data_gridData !== 4'h5) begin
      fails++;
      $display("FAIL idle_hold: got wren=%b addr=%h data=%h, want 0 123 5",
               wren_gridData, wraddress_gridData, data_gridData);
    end
  endtask

  task automatic test_clear_priority;
    int  writes;
    int  gnt_bad;
    bit  seen_done;
    clear_start = 1'b1;
    p2_req = 1'b1; p2_addr = 12'h2AB; p2_color = 4'hC;
    #1;
    tests++;
    if (p2_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL clear_priority_grant: got p1_gnt=%b p2_gnt=%b, want 0 0", p1_gnt, p2_gnt);
    end
    tick();
    clear_start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b1 || wren_gridData !== 1'b1 || wraddress_gridData !== 12'd0 ||
        data_gridData !== 4'd0) begin
      fails++;
      $display("FAIL clear_first_write: got busy=%b wren=%b addr=%0d data=%0d, want 1 1 0 0",
               busy, wren_gridData, wraddress_gridData, data_gridData);
    end
    writes    = 1;
    gnt_bad   = 0;
    seen_done = 1'b0;
    for (int j = 0; j < 5000; j++) begin
      if (j == 100) clear_start = 1'b1;
      if (j == 101) clear_start = 1'b0;
      #1;
      if (p1_gnt || p2_gnt) gnt_bad++;
      tick();
      if (clear_done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) writes++;
    end
    clear_start = 1'b0;
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL clear_done_timeout: got no clear_done within 5000 cycles, want one");
    end
    tests++;
    if (writes != 4096) begin
      fails++;
      $display("FAIL clear_write_count: got %0d busy writes, want 4096", writes);
    end
    tests++;
    if (gnt_bad != 0) begin
      fails++;
      $display("FAIL clear_no_grant: got %0d grant cycles during sweep, want 0", gnt_bad);
    end
    tests++;
    if (p2_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL pending_p2_grant: got p1_gnt=%b p2_gnt=%b, want 0 1", p1_gnt, p2_gnt);
    end
    tick();
    p2_req = 1'b0;
    tests++;
    if (wren_gridData !== 1'b1 || wraddress_gridData !== 12'h2AB || data_gridData !== 4'hC) begin
      fails++;
      $display("FAIL pending_p2_write: got wren=%b addr=%h data=%h, want 1 2ab c",
               wren_gridData, wraddress_gridData, data_gridData);
    end
  endtask

  task automatic test_reset_abort;
    bit seen;
    bit seen_done;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      tick();
      if (busy && wraddress_gridData == 12'd2000) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL abort_reach_2000: got no sweep address 2000 within 3000 cycles, want it");
    end
    p1_req = 1'b1; p1_addr = 12'h777; p1_color = 4'h9;
    resetn = 1'b0;
    tick();
    tests++;
    if ({wren_gridData, busy, clear_done, wraddress_gridData, data_gridData,
         p1_gnt, p2_gnt} !== 21'd0) begin
      fails++;
      $display("FAIL abort_outputs: got wren=%b busy=%b done=%b addr=%0d data=%0d gnt=%b%b, want 0",
               wren_gridData, busy, clear_done, wraddress_gridData, data_gridData, p1_gnt, p2_gnt);
    end
    resetn = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b1 || wren_gridData !== 1'b1 || wraddress_gridData !== 12'd0 ||
        clear_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_restart: got busy=%b wren=%b addr=%0d done=%b, want 1 1 0 0",
               busy, wren_gridData, wraddress_gridData, clear_done);
    end
    seen_done = 1'b0;
    for (int j = 0; j < 5000; j++) begin
      tick();
      if (clear_done) begin
        seen_done = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL abort_sweep_done: got no clear_done within 5000 cycles, want one");
    end
    tests++;
    if (p1_gnt !== 1'b1) begin
      fails++;
      $display("FAIL abort_pending_p1: got p1_gnt=%b, want 1", p1_gnt);
    end
    p1_req = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    resetn      = 1'b0;
    p1_req      = 1'b0;
    p1_addr     = '0;
    p1_color    = '0;
    p2_req      = 1'b0;
    p2_addr     = '0;
    p2_color    = '0;
    clear_start = 1'b0;
    test_reset();
    test_tie();
    test_single_p1();
    test_clear_priority();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
